// File: rtl/kbd_pkg.sv
// Shared scancode constants, parser state and event bundle
// for the keyboard event sequencer.
package kbd_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_OVR0   = 8'h00;
    localparam logic [7:0] SC_OVRF   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0,
        ST_GAP,
        ST_EMIT
    } parse_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
    } kbd_evt_t;

    // States in which a byte may be taken from the FIFO.
    function automatic logic is_pop_state(input parse_state_e s);
        return (s == ST_IDLE) || (s == ST_GOT_E0) ||
               (s == ST_GOT_F0) || (s == ST_GOT_E0F0);
    endfunction

endpackage

// File: rtl/kbd_mod_tracker.sv
// Held key, shift/ctrl/caps state and press counter,
// updated once per accepted event.
module kbd_mod_tracker
    import kbd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  kbd_evt_t         i_evt,
    input  logic             i_upd,
    output logic             o_held_vld,
    output logic             o_held_ext,
    output logic [7:0]       o_held_code,
    output logic             o_shift,
    output logic             o_ctrl,
    output logic             o_caps,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic             r_held_vld;
    logic             r_held_ext;
    logic [7:0]       r_held_code;
    logic             r_lsh;
    logic             r_rsh;
    logic             r_lct;
    logic             r_rct;
    logic             r_caps;
    logic [CNT_W-1:0] r_count;

    logic w_hit;
    logic w_lsh;
    logic w_rsh;
    logic w_lct;
    logic w_rct;
    logic w_caps;

    assign w_hit  = r_held_vld && (r_held_ext == i_evt.ext) &&
                    (r_held_code == i_evt.code);
    assign w_lsh  = !i_evt.ext && (i_evt.code == SC_LSHIFT);
    assign w_rsh  = !i_evt.ext && (i_evt.code == SC_RSHIFT);
    assign w_lct  = !i_evt.ext && (i_evt.code == SC_CTRL);
    assign w_rct  = i_evt.ext && (i_evt.code == SC_CTRL);
    assign w_caps = !i_evt.ext && (i_evt.code == SC_CAPS);

    // Apply make/break side effects; repeats leave everything alone.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_held_vld  <= 1'b0;
            r_held_ext  <= 1'b0;
            r_held_code <= 8'h00;
            r_lsh       <= 1'b0;
            r_rsh       <= 1'b0;
            r_lct       <= 1'b0;
            r_rct       <= 1'b0;
            r_caps      <= 1'b0;
            r_count     <= '0;
        end else if (i_upd) begin
            if (!i_evt.brk) begin
                if (!i_evt.rpt) begin
                    r_held_vld  <= 1'b1;
                    r_held_ext  <= i_evt.ext;
                    r_held_code <= i_evt.code;
                    r_count     <= r_count + ONE;
                    if (w_caps) r_caps <= !r_caps;
                    if (w_lsh)  r_lsh  <= 1'b1;
                    if (w_rsh)  r_rsh  <= 1'b1;
                    if (w_lct)  r_lct  <= 1'b1;
                    if (w_rct)  r_rct  <= 1'b1;
                end
            end else begin
                if (w_hit) r_held_vld <= 1'b0;
                if (w_lsh) r_lsh <= 1'b0;
                if (w_rsh) r_rsh <= 1'b0;
                if (w_lct) r_lct <= 1'b0;
                if (w_rct) r_rct <= 1'b0;
            end
        end
    end

    assign o_held_vld  = r_held_vld;
    assign o_held_ext  = r_held_ext;
    assign o_held_code = r_held_code;
    assign o_shift     = r_lsh | r_rsh;
    assign o_ctrl      = r_lct | r_rct;
    assign o_caps      = r_caps;
    assign o_count     = r_count;

endmodule

// File: rtl/kbd_event_ctrl.sv
// Pops PS/2 bytes, folds E0/F0 prefixes into make/break
// events and hands them out over valid/ready.
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter bit EMIT_REPEAT = 1'b0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       fifo_data,
    input  logic             fifo_ready,
    output logic             fifo_pop_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic             mod_shift,
    output logic             mod_ctrl,
    output logic             caps_lock,
    output logic [CNT_W-1:0] key_count,
    output logic             err
);

    parse_state_e r_state;
    parse_state_e r_prev;
    logic [7:0]   r_byte;
    kbd_evt_t     r_evt;
    logic         r_err;

    parse_state_e w_nxt;
    logic         w_pop;
    logic         w_err;
    logic         w_upd;
    logic         w_ext;
    logic         w_brk;
    logic         w_rpt;
    kbd_evt_t     w_cand;
    logic         w_held_vld;
    logic         w_held_ext;
    logic [7:0]   w_held_code;

    // Pop is gated by reset so the FIFO is never drained while held.
    assign w_pop = clrn && fifo_ready && is_pop_state(r_state);

    assign w_ext = (r_prev == ST_GOT_E0) || (r_prev == ST_GOT_E0F0);
    assign w_brk = (r_prev == ST_GOT_F0) || (r_prev == ST_GOT_E0F0);
    assign w_rpt = !w_brk && w_held_vld &&
                   (w_held_ext == w_ext) && (w_held_code == r_byte);

    assign w_cand = '{code: r_byte, ext: w_ext, brk: w_brk, rpt: w_rpt};

    // Next state; byte decoding happens in GAP against the pre-pop state.
    always_comb begin
        w_nxt = r_state;
        w_err = 1'b0;
        w_upd = 1'b0;
        case (r_state)
            ST_IDLE, ST_GOT_E0, ST_GOT_F0, ST_GOT_E0F0: begin
                if (w_pop) w_nxt = ST_GAP;
            end
            ST_GAP: begin
                unique case (1'b1)
                    r_byte == SC_E0: begin
                        if (r_prev == ST_IDLE) begin
                            w_nxt = ST_GOT_E0;
                        end else begin
                            w_nxt = ST_IDLE;
                            w_err = 1'b1;
                        end
                    end
                    r_byte == SC_F0: begin
                        if (r_prev == ST_IDLE) begin
                            w_nxt = ST_GOT_F0;
                        end else if (r_prev == ST_GOT_E0) begin
                            w_nxt = ST_GOT_E0F0;
                        end else begin
                            w_nxt = ST_IDLE;
                            w_err = 1'b1;
                        end
                    end
                    (r_byte == SC_BAT) || (r_byte == SC_ACK) ||
                    (r_byte == SC_ECHO): begin
                        w_nxt = r_prev;
                    end
                    (r_byte == SC_OVR0) || (r_byte == SC_OVRF) ||
                    (r_byte == SC_E1): begin
                        w_nxt = ST_IDLE;
                        w_err = 1'b1;
                    end
                    default: begin
                        if (w_rpt && !EMIT_REPEAT) begin
                            w_nxt = ST_IDLE;
                        end else begin
                            w_nxt = ST_EMIT;
                            w_upd = 1'b1;
                        end
                    end
                endcase
            end
            ST_EMIT: begin
                if (evt_ready) w_nxt = ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    // Parser registers: state, latched byte, held event, error pulse.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
            r_prev  <= ST_IDLE;
            r_byte  <= 8'h00;
            r_evt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_err   <= w_err;
            if (w_pop) begin
                r_byte <= fifo_data;
                r_prev <= r_state;
            end
            if (w_upd) r_evt <= w_cand;
        end
    end

    kbd_mod_tracker #(
        .CNT_W (CNT_W)
    ) u_trk (
        .clk         (clk),
        .clrn        (clrn),
        .i_evt       (w_cand),
        .i_upd       (w_upd),
        .o_held_vld  (w_held_vld),
        .o_held_ext  (w_held_ext),
        .o_held_code (w_held_code),
        .o_shift     (mod_shift),
        .o_ctrl      (mod_ctrl),
        .o_caps      (caps_lock),
        .o_count     (key_count)
    );

    assign fifo_pop_n = !w_pop;
    assign evt_valid  = (r_state == ST_EMIT);
    assign evt_code   = r_evt.code;
    assign evt_ext    = r_evt.ext;
    assign evt_break  = r_evt.brk;
    assign evt_repeat = r_evt.rpt;
    assign err        = r_err;

endmodule
